// File: rtl/apb_completer_pkg.sv
// Shared types and address helpers for the APB completer memory.
// Helpers take widths as arguments so one package serves every parameterisation.
package apb_completer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    // Byte-offset bits inside one data word.
    function automatic int lsb_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // An access errors when its word index is out of range or it is not word aligned.
    function automatic logic addr_error(input logic [63:0] addr,
                                        input int          data_w,
                                        input int          depth);
        int          lsb;
        logic [63:0] idx;
        logic [63:0] mask;
        lsb  = lsb_of(data_w);
        idx  = addr >> lsb;
        mask = (64'd1 << lsb) - 64'd1;
        return (idx >= 64'(depth)) || ((addr & mask) != 64'd0);
    endfunction

endpackage

// File: rtl/apb_completer_ram.sv
// Word-addressed storage with a byte-enable write port and a registered read port.
// The read register returns zero whenever no read is requested.
module apb_completer_ram
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer serving a local memory with programmable wait states,
// address error responses and a sticky requester protocol-violation flag.
module apb_completer_mem
    import apb_completer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int PSEL_W  = 16,
    parameter int SEL_IDX = 0,
    parameter int WAIT_W  = 4
)
(
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [PSEL_W-1:0]   PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [WAIT_W-1:0]   wait_cfg,
    output logic                proto_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = lsb_of(DATA_W);
    localparam int IDX_W  = idx_width(DEPTH);

    state_t              state;
    state_t              state_n;
    logic [WAIT_W-1:0]   cnt;
    logic [WAIT_W-1:0]   cnt_n;
    logic                latch;
    logic                proto_set;

    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;

    logic [ADDR_W-1:0]   addr_n;
    logic                write_n;
    logic                err_n;
    logic                err_cur;

    logic                pready_q;
    logic                pslverr_q;
    logic                proto_err_q;

    logic                sel;
    logic                ram_we;
    logic                ram_re;
    logic [IDX_W-1:0]    ram_waddr;
    logic [IDX_W-1:0]    ram_raddr;
    logic                unused_psel;

    assign sel         = PSEL[SEL_IDX];
    assign unused_psel = ^PSEL;

    // Next-state logic; an abort from WAIT never reaches READY, so it never writes.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        latch     = 1'b0;
        proto_set = 1'b0;
        case (state)
            IDLE: begin
                if (sel && !PENABLE) begin
                    latch   = 1'b1;
                    cnt_n   = wait_cfg;
                    state_n = (wait_cfg == '0) ? READY : WAIT;
                end else if (sel && PENABLE) begin
                    proto_set = 1'b1;
                end
            end
            WAIT: begin
                if (!sel || !PENABLE) begin
                    proto_set = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt - WAIT_W'(1);
                    if (cnt == WAIT_W'(1)) begin
                        state_n = READY;
                    end
                end
            end
            READY: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The transfer attributes as they will be held next cycle, so registered
    // outputs can be computed even when setup goes straight to READY.
    always_comb begin
        addr_n  = latch ? PADDR : addr_q;
        write_n = latch ? PWRITE : write_q;
        err_n   = addr_error(64'(addr_n), DATA_W, DEPTH);
        err_cur = addr_error(64'(addr_q), DATA_W, DEPTH);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pready_q    <= (state_n == READY);
            pslverr_q   <= (state_n == READY) && err_n;
            proto_err_q <= proto_err_q | proto_set;
            if (latch) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
        end
    end

    // Writes commit at the end of READY; reads are fetched on the edge entering READY.
    assign ram_we    = PRESETn && (state == READY) && write_q && !err_cur;
    assign ram_re    = (state_n == READY) && !write_n && !err_n;
    assign ram_waddr = IDX_W'(addr_q >> LSB);
    assign ram_raddr = IDX_W'(addr_n >> LSB);

    apb_completer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (ram_we),
        .be    (strb_q),
        .waddr (ram_waddr),
        .wdata (wdata_q),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (PRDATA)
    );

    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign proto_err = proto_err_q;

endmodule
